ps2_key_sender: RTL and testbench

PS2_KEY_SENDER -- requirements
Module: ps2_key_sender

---
 rtl/ps2_key_sender_pkg.sv | 21 ++
 rtl/ps2_frame_tx.sv | 99 +++++++++
 rtl/ps2_key_sender.sv | 130 +++++++++++++
 tb/tb_ps2_key_sender.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_sender_pkg.sv
// Shared definitions for the PS/2 key sender.
// This package holds the sequencer states, the frame constants and the parity helper.
package ps2_key_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F0_FRAME,
    ST_F0_GAP,
    ST_CODE_FRAME,
    ST_CODE_GAP
  } seq_state_t;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam int         FRAME_BITS   = 11;

  // Returns the bit that makes the ones count of data plus parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device-to-host frame.
// Each bit spends CLK_DIV cycles with the clock high and then CLK_DIV cycles with it low.
module ps2_frame_tx
  import ps2_key_sender_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_word;
  logic                  active_q, active_d;
  logic                  clk_q, clk_d;
  logic                  data_q, data_d;
  logic [7:0]            div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-2:0] shift_q, shift_d;
  logic                  div_last;

  assign frame_word[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_data_bits
      assign frame_word[gi+1] = tx_byte[gi];
    end
  endgenerate
  assign frame_word[9]  = odd_parity(tx_byte);
  assign frame_word[10] = 1'b1;

  assign div_last = (div_q == DIV_LAST);
  assign done     = active_q && !clk_q && div_last && (bit_q == BIT_LAST);

  always_comb begin
    active_d = active_q;
    clk_d    = clk_q;
    data_d   = data_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (start) begin
      active_d = 1'b1;
      clk_d    = 1'b1;
      data_d   = frame_word[0];
      shift_d  = frame_word[FRAME_BITS-1:1];
      div_d    = '0;
      bit_d    = '0;
    end else if (active_q) begin
      if (div_last) begin
        div_d = '0;
        if (clk_q) begin
          clk_d = 1'b0;
        end else if (bit_q == BIT_LAST) begin
          active_d = 1'b0;
          clk_d    = 1'b1;
          data_d   = 1'b1;
          bit_d    = '0;
        end else begin
          // Data only moves together with the rising clock, so it is settled long before the fall.
          clk_d   = 1'b1;
          data_d  = shift_q[0];
          shift_d = {1'b1, shift_q[FRAME_BITS-2:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      clk_q    <= 1'b1;
      data_q   <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
    end else begin
      active_q <= active_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;

endmodule

// File: rtl/ps2_key_sender.sv
// PS/2 keyboard device emulator: accepts one key event, optionally sends a break prefix, then sends the scan code.
// Each frame is followed by an idle gap, and the module counts the frames it completes.
module ps2_key_sender
  import ps2_key_sender_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_break,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       key_ready_q, key_ready_d;
  logic       busy_q, busy_d;
  logic [7:0] frames_q, frames_d;
  logic [7:0] gap_q, gap_d;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_done;
  logic       accept;
  logic       gap_last;

  // key_ready_q is only ever high in IDLE, so it doubles as the IDLE qualifier.
  assign accept   = key_valid && key_ready_q;
  assign gap_last = (gap_q == GAP_LAST);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    tx_start = 1'b0;
    tx_byte  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          code_d   = key_code;
          tx_start = 1'b1;
          // The break flag is held in the choice of the F0 path.
          if (key_break) begin
            tx_byte = BREAK_PREFIX;
            state_d = ST_F0_FRAME;
          end else begin
            tx_byte = key_code;
            state_d = ST_CODE_FRAME;
          end
        end
      end
      ST_F0_FRAME: begin
        if (tx_done) begin
          state_d  = ST_F0_GAP;
          gap_d    = '0;
          frames_d = frames_q + 8'd1;
        end
      end
      ST_F0_GAP: begin
        if (gap_last) begin
          state_d  = ST_CODE_FRAME;
          tx_start = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_CODE_FRAME: begin
        if (tx_done) begin
          state_d  = ST_CODE_GAP;
          gap_d    = '0;
          frames_d = frames_q + 8'd1;
        end
      end
      ST_CODE_GAP: begin
        if (gap_last) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    key_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      frames_q    <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      frames_q    <= frames_d;
      gap_q       <= gap_d;
    end
  end

  ps2_frame_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_frame_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (tx_start),
    .tx_byte (tx_byte),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .done    (tx_done)
  );

  assign key_ready   = key_ready_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_ps2_key_sender.sv
// Directed testbench for ps2_key_sender with CLK_DIV=4 and GAP_CYCLES=16.
// It records the output lines cycle by cycle and decodes the frames at the falling edges of ps2_clk.
module tb_ps2_key_sender;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] frames_sent;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_frames;

  logic       tr_clk   [0:255];
  logic       tr_data  [0:255];
  logic       tr_ready [0:255];
  logic       tr_busy  [0:255];
  logic [7:0] tr_frames[0:255];

  ps2_key_sender #(
    .CLK_DIV   (4),
    .GAP_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_break  (key_break),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Index i in the trace holds the outputs one step after the (base+i)-th recorded rising edge.
  task automatic rec_cycles(input int base, input int n, input bit keep_valid);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tr_clk[base+i]    = ps2_clk;
      tr_data[base+i]   = ps2_data;
      tr_ready[base+i]  = key_ready;
      tr_busy[base+i]   = busy;
      tr_frames[base+i] = frames_sent;
      if (!keep_valid) key_valid = 1'b0;
    end
  endtask

  task automatic decode(input int base, input int n, output logic [10:0] bits,
                        output int nfall, output int flen, output int unstable);
    int first_idx;
    int last_low;
    bits = '0;
    nfall = 0;
    unstable = 0;
    first_idx = -1;
    last_low = -1;
    for (int i = base; i < base + n; i++) begin
      if (first_idx < 0 && !(tr_clk[i] && tr_data[i])) first_idx = i;
      if (!tr_clk[i]) last_low = i;
      if (i > base && !tr_clk[i] && tr_data[i-1] !== tr_data[i]) unstable++;
      if (i > base && tr_clk[i-1] && !tr_clk[i]) begin
        if (nfall < 11) bits[nfall] = tr_data[i];
        nfall++;
      end
    end
    flen = (first_idx < 0 || last_low < 0) ? 0 : last_low - first_idx + 1;
  endtask

  function automatic int count_not_high(input int base, input int n);
    int c = 0;
    for (int i = base; i < base + n; i++)
      if (!(tr_clk[i] === 1'b1 && tr_data[i] === 1'b1)) c++;
    return c;
  endfunction

  task automatic test_reset;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL reset_clk: got %b want 1", ps2_clk); end
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL reset_data: got %b want 1", ps2_data); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", key_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL reset_frames: got %h want 00", frames_sent); end
    rst = 1'b0;
    #1;
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_before_edge: got %b want 0", key_ready); end
    @(posedge clk);
    #1;
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise: got %b want 1", key_ready); end
    exp_frames = 8'h00;
    $display("reset: released, key_ready=%b", key_ready);
  endtask

  task automatic test_make;
    logic [10:0] bits;
    int nfall, flen, unstable;
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL make_pre_ready: got %b want 1", key_ready); end
    key_code = 8'h1C; key_break = 1'b0; key_valid = 1'b1;
    rec_cycles(0, 106, 1'b0);
    decode(0, 104, bits, nfall, flen, unstable);
    total++; if (tr_data[0] !== 1'b0) begin bad++; $display("FAIL make_start_bit: got %b want 0", tr_data[0]); end
    total++; if (tr_ready[0] !== 1'b0) begin bad++; $display("FAIL make_ready_drop: got %b want 0", tr_ready[0]); end
    total++; if (tr_busy[0] !== 1'b1) begin bad++; $display("FAIL make_busy: got %b want 1", tr_busy[0]); end
    total++; if (bits !== 11'b10000111000) begin bad++; $display("FAIL make_bits: got %b want 10000111000", bits); end
    total++; if (nfall !== 11) begin bad++; $display("FAIL make_falls: got %0d want 11", nfall); end
    total++; if (flen !== 88) begin bad++; $display("FAIL make_len: got %0d want 88", flen); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL make_data_stable: got %0d changes want 0", unstable); end
    total++; if (count_not_high(88, 16) !== 0) begin bad++; $display("FAIL make_gap_high: got %0d low cycles want 0", count_not_high(88, 16)); end
    total++; if (tr_frames[87] !== exp_frames) begin bad++; $display("FAIL make_count_early: got %h want %h", tr_frames[87], exp_frames); end
    exp_frames = exp_frames + 8'd1;
    total++; if (tr_frames[88] !== exp_frames) begin bad++; $display("FAIL make_count: got %h want %h", tr_frames[88], exp_frames); end
    total++; if (tr_ready[103] !== 1'b0) begin bad++; $display("FAIL make_ready_early: got %b want 0", tr_ready[103]); end
    total++; if (tr_ready[104] !== 1'b1) begin bad++; $display("FAIL make_ready_104: got %b want 1", tr_ready[104]); end
    total++; if (tr_busy[104] !== 1'b0) begin bad++; $display("FAIL make_busy_end: got %b want 0", tr_busy[104]); end
    $display("make 1c: bits=%b len=%0d frames=%h", bits, flen, tr_frames[105]);
  endtask

  task automatic test_break;
    logic [10:0] bits;
    int nfall, flen, unstable;
    key_code = 8'h1C; key_break = 1'b1; key_valid = 1'b1;
    rec_cycles(0, 210, 1'b0);
    key_break = 1'b0;
    decode(0, 104, bits, nfall, flen, unstable);
    total++; if (bits !== 11'b11111100000) begin bad++; $display("FAIL break_f0_bits: got %b want 11111100000", bits); end
    total++; if (flen !== 88) begin bad++; $display("FAIL break_f0_len: got %0d want 88", flen); end
    total++; if (count_not_high(88, 16) !== 0) begin bad++; $display("FAIL break_gap1_high: got %0d want 0", count_not_high(88, 16)); end
    decode(104, 104, bits, nfall, flen, unstable);
    total++; if (bits !== 11'b10000111000) begin bad++; $display("FAIL break_code_bits: got %b want 10000111000", bits); end
    total++; if (flen !== 88) begin bad++; $display("FAIL break_code_len: got %0d want 88", flen); end
    total++; if (tr_data[104] !== 1'b0) begin bad++; $display("FAIL break_code_start: got %b want 0", tr_data[104]); end
    total++; if (count_not_high(192, 16) !== 0) begin bad++; $display("FAIL break_gap2_high: got %0d want 0", count_not_high(192, 16)); end
    total++; if (tr_frames[88] !== exp_frames + 8'd1) begin bad++; $display("FAIL break_count1: got %h want %h", tr_frames[88], exp_frames + 8'd1); end
    exp_frames = exp_frames + 8'd2;
    total++; if (tr_frames[192] !== exp_frames) begin bad++; $display("FAIL break_count2: got %h want %h", tr_frames[192], exp_frames); end
    total++; if (tr_ready[207] !== 1'b0) begin bad++; $display("FAIL break_ready_early: got %b want 0", tr_ready[207]); end
    total++; if (tr_ready[208] !== 1'b1) begin bad++; $display("FAIL break_ready_208: got %b want 1", tr_ready[208]); end
    $display("break 1c: frames=%h ready_at=208", tr_frames[209]);
  endtask

  task automatic test_back_to_back;
    logic [10:0] bits;
    int nfall, flen, unstable;
    key_code = 8'h1C; key_break = 1'b0; key_valid = 1'b1;
    rec_cycles(0, 1, 1'b1);
    key_code = 8'h12;
    rec_cycles(1, 104, 1'b1);
    decode(0, 104, bits, nfall, flen, unstable);
    total++; if (bits !== 11'b10000111000) begin bad++; $display("FAIL b2b_first_bits: got %b want 10000111000", bits); end
    total++; if (count_not_high(88, 16) !== 0) begin bad++; $display("FAIL b2b_gap_high: got %0d want 0", count_not_high(88, 16)); end
    total++; if (tr_ready[103] !== 1'b0) begin bad++; $display("FAIL b2b_ready_early: got %b want 0", tr_ready[103]); end
    total++; if (tr_ready[104] !== 1'b1) begin bad++; $display("FAIL b2b_ready_104: got %b want 1", tr_ready[104]); end
    rec_cycles(105, 106, 1'b0);
    decode(105, 104, bits, nfall, flen, unstable);
    total++; if (tr_data[105] !== 1'b0) begin bad++; $display("FAIL b2b_second_start: got %b want 0", tr_data[105]); end
    total++; if (bits !== 11'b11000100100) begin bad++; $display("FAIL b2b_second_bits: got %b want 11000100100", bits); end
    total++; if (bits[9] !== 1'b1) begin bad++; $display("FAIL b2b_parity_12: got %b want 1", bits[9]); end
    total++; if (flen !== 88) begin bad++; $display("FAIL b2b_second_len: got %0d want 88", flen); end
    exp_frames = exp_frames + 8'd2;
    total++; if (tr_frames[193] !== exp_frames) begin bad++; $display("FAIL b2b_count: got %h want %h", tr_frames[193], exp_frames); end
    total++; if (tr_ready[209] !== 1'b1) begin bad++; $display("FAIL b2b_ready_end: got %b want 1", tr_ready[209]); end
    $display("back_to_back 1c->12: second bits=%b", bits);
  endtask

  task automatic test_f0_plain;
    logic [10:0] bits;
    int nfall, flen, unstable;
    key_code = 8'hF0; key_break = 1'b0; key_valid = 1'b1;
    rec_cycles(0, 106, 1'b0);
    decode(0, 104, bits, nfall, flen, unstable);
    total++; if (bits !== 11'b11111100000) begin bad++; $display("FAIL f0_plain_bits: got %b want 11111100000", bits); end
    total++; if (count_not_high(88, 16) !== 0) begin bad++; $display("FAIL f0_plain_gap: got %0d want 0", count_not_high(88, 16)); end
    total++; if (tr_ready[104] !== 1'b1) begin bad++; $display("FAIL f0_plain_ready: got %b want 1", tr_ready[104]); end
    exp_frames = exp_frames + 8'd1;
    total++; if (tr_frames[105] !== exp_frames) begin bad++; $display("FAIL f0_plain_count: got %h want %h", tr_frames[105], exp_frames); end
    $display("make f0: single frame bits=%b", bits);
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] bits;
    int nfall, flen, unstable;
    key_code = 8'h12; key_break = 1'b0; key_valid = 1'b1;
    rec_cycles(0, 38, 1'b0);
    total++; if (tr_clk[37] !== 1'b0) begin bad++; $display("FAIL midrst_pre_clk: got %b want 0", tr_clk[37]); end
    total++; if (tr_data[37] !== 1'b0) begin bad++; $display("FAIL midrst_pre_data: got %b want 0", tr_data[37]); end
    rst = 1'b1;
    #1;
    total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL midrst_clk: got %b want 1", ps2_clk); end
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL midrst_data: got %b want 1", ps2_data); end
    total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL midrst_frames: got %h want 00", frames_sent); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", key_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rec_cycles(38, 3, 1'b0);
    rst = 1'b0;
    rec_cycles(41, 20, 1'b0);
    total++; if (tr_ready[41] !== 1'b1) begin bad++; $display("FAIL midrst_ready_rise: got %b want 1", tr_ready[41]); end
    total++; if (count_not_high(38, 23) !== 0) begin bad++; $display("FAIL midrst_no_resume: got %0d want 0", count_not_high(38, 23)); end
    exp_frames = 8'h00;
    key_code = 8'h16; key_valid = 1'b1;
    rec_cycles(0, 106, 1'b0);
    decode(0, 104, bits, nfall, flen, unstable);
    total++; if (bits !== 11'b10000101100) begin bad++; $display("FAIL midrst_16_bits: got %b want 10000101100", bits); end
    total++; if (flen !== 88) begin bad++; $display("FAIL midrst_16_len: got %0d want 88", flen); end
    exp_frames = exp_frames + 8'd1;
    total++; if (tr_frames[88] !== exp_frames) begin bad++; $display("FAIL midrst_16_count: got %h want %h", tr_frames[88], exp_frames); end
    $display("reset mid-frame: then make 16 bits=%b", bits);
  endtask

  task automatic test_wrap;
    logic [10:0] bits;
    logic [10:0] want;
    logic [7:0]  code;
    int nfall, flen, unstable;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_frames = 8'h00;
    for (int ev = 0; ev < 256; ev++) begin
      code = 8'(ev);
      want = {1'b1, ~^code, code, 1'b0};
      key_code = code; key_break = 1'b0; key_valid = 1'b1;
      rec_cycles(0, 105, 1'b0);
      decode(0, 104, bits, nfall, flen, unstable);
      exp_frames = exp_frames + 8'd1;
      total++; if (bits !== want) begin bad++; $display("FAIL wrap_bits ev=%0d: got %b want %b", ev, bits, want); end
      total++; if (count_not_high(88, 16) !== 0) begin bad++; $display("FAIL wrap_gap ev=%0d: got %0d want 0", ev, count_not_high(88, 16)); end
      total++; if (tr_ready[104] !== 1'b1) begin bad++; $display("FAIL wrap_ready ev=%0d: got %b want 1", ev, tr_ready[104]); end
      total++; if (tr_frames[104] !== exp_frames) begin bad++; $display("FAIL wrap_count ev=%0d: got %h want %h", ev, tr_frames[104], exp_frames); end
      $display("wrap event %0d: code=%h frames=%h", ev, code, tr_frames[104]);
    end
    total++; if (frames_sent !== 8'h00) begin bad++; $display("FAIL wrap_final: got %h want 00", frames_sent); end
  endtask

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 8'h00;
    key_break = 1'b0;
    exp_frames = 8'h00;
    test_reset;
    test_make;
    test_break;
    test_back_to_back;
    test_f0_plain;
    test_reset_mid_frame;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
